// File: rtl/regfile_pkg.sv
// Shared sizing for the general register array read path.
// Word k of the flattened array output sits at bit word_lsb(k, word width).
package regfile_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_COUNT      = 32;
  localparam int ADDR_W         = 5;
  localparam int WORD_W_DEFAULT = XLEN_DEFAULT + 1;
  localparam int STALL_W        = 16;

  function automatic int word_lsb(input int k, input int word_w);
    return k * word_w;
  endfunction

endpackage

// File: rtl/regread_port_if.sv
// Decode-to-execute operand read bus: request (rs1/rs2) in, registered operands out.
// Both halves use valid/ready; master is the decode/execute side, slave is the read port.
interface regread_port_if #(
  parameter int XLEN = regfile_pkg::XLEN_DEFAULT
);

  logic                        in_valid;
  logic                        in_ready;
  logic [regfile_pkg::ADDR_W-1:0] rs1;
  logic [regfile_pkg::ADDR_W-1:0] rs2;
  logic                        out_valid;
  logic                        out_ready;
  logic [XLEN:0]               op1;
  logic [XLEN:0]               op2;

  modport master (
    output in_valid, rs1, rs2, out_ready,
    input  in_ready, out_valid, op1, op2
  );

  modport slave (
    input  in_valid, rs1, rs2, out_ready,
    output in_ready, out_valid, op1, op2
  );

endinterface

// File: rtl/regread_port_regsel.sv
// One operand select: 32:1 word mux with x0 forced to zero and same-cycle write forwarding.
// Purely combinational; o_hazard flags a pending write not satisfied by this cycle's commit.
module regsel
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [REG_COUNT*(XLEN+1)-1:0] i_regs_flat,
  input  logic [XLEN:0]                 i_g,
  input  logic [XLEN-1:0]               i_r_in,
  input  logic [XLEN-1:0]               i_pend,
  input  logic [ADDR_W-1:0]             i_sel,
  output logic [XLEN:0]                 o_word,
  output logic                          o_hazard
);

  localparam int W = XLEN + 1;

  logic [W-1:0] w_words [REG_COUNT];
  logic [W-1:0] w_stored;
  logic         w_nz;
  logic         w_fwd;

  for (genvar k = 0; k < REG_COUNT; k++) begin : g_unpack
    assign w_words[k] = i_regs_flat[word_lsb(k, W) +: W];
  end

  assign w_stored = w_words[i_sel];
  assign w_nz     = |i_sel;
  assign w_fwd    = i_r_in[i_sel];

  // x0 wins over everything; a committing write beats both the array and the scoreboard.
  assign o_word   = !w_nz ? '0 : (w_fwd ? i_g : w_stored);
  assign o_hazard = w_nz && i_pend[i_sel] && !w_fwd;

endmodule

// File: rtl/regread_port.sv
// Register-array read port: selects two operands and holds them in a 1-cycle valid/ready stage.
// Holds outputs under backpressure; refuses requests whose sources have pending writes.
module regread_port
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [REG_COUNT*(XLEN+1)-1:0] regs_flat,
  input  logic [XLEN:0]                 G,
  input  logic [XLEN-1:0]               R_in,
  input  logic [XLEN-1:0]               pend,
  regread_port_if.slave                 bus,
  output logic [STALL_W-1:0]            stall_cnt
);

  logic [XLEN:0]        w_sel1;
  logic [XLEN:0]        w_sel2;
  logic                 w_haz1;
  logic                 w_haz2;
  logic                 w_hazard;
  logic                 w_in_ready;
  logic                 w_accept;

  logic                 r_out_valid;
  logic [XLEN:0]        r_op1;
  logic [XLEN:0]        r_op2;
  logic [STALL_W-1:0]   r_stall_cnt;

  regsel #(.XLEN(XLEN)) u_sel_rs1 (
    .i_regs_flat (regs_flat),
    .i_g         (G),
    .i_r_in      (R_in),
    .i_pend      (pend),
    .i_sel       (bus.rs1),
    .o_word      (w_sel1),
    .o_hazard    (w_haz1)
  );

  regsel #(.XLEN(XLEN)) u_sel_rs2 (
    .i_regs_flat (regs_flat),
    .i_g         (G),
    .i_r_in      (R_in),
    .i_pend      (pend),
    .i_sel       (bus.rs2),
    .o_word      (w_sel2),
    .o_hazard    (w_haz2)
  );

  assign w_hazard   = bus.in_valid && (w_haz1 || w_haz2);
  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Operands are a snapshot at the accepting edge; later writes do not refresh them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op1       <= w_sel1;
      r_op2       <= w_sel2;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Only hazard cycles count; pure backpressure is not a stall here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {STALL_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op1       = r_op1;
  assign bus.op2       = r_op2;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_regread_port.sv
// Directed bench for regread_port: forwarding, x0, hazard stalls, backpressure, async reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_regread_port;

  localparam int XLEN = 32;
  localparam int W    = XLEN + 1;

  logic            clk;
  logic            resetn;
  logic [32*W-1:0] regs_flat;
  logic [XLEN:0]   G;
  logic [XLEN-1:0] R_in;
  logic [XLEN-1:0] pend;
  logic [15:0]     stall_cnt;

  int checks;
  int failures;

  regread_port_if #(.XLEN(XLEN)) bus ();

  regread_port #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .regs_flat (regs_flat),
    .G         (G),
    .R_in      (R_in),
    .pend      (pend),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int k, input logic [W-1:0] v);
    regs_flat[k*W +: W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    resetn        = 1'b0;
    regs_flat     = '0;
    G             = '0;
    R_in          = '0;
    pend          = '0;
    bus.in_valid  = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_op1", 64'(bus.op1), 64'd0);
    check("rst_op2", 64'(bus.op2), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // Plain read of r3/r5
    set_reg(3, 33'h0_0000_0011);
    set_reg(5, 33'h1_0000_0022);
    bus.rs1 = 5'd3; bus.rs2 = 5'd5; bus.in_valid = 1'b1;
    #1;
    check("t1_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_op1", 64'(bus.op1), 64'h0_0000_0011);
    check("t1_op2", 64'(bus.op2), 64'h1_0000_0022);

    // x0 ignores pend and R_in
    pend = '1; R_in = 32'h1; G = 33'h1_FFFF_FFFF;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.in_valid = 1'b1;
    #1;
    check("t2_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_op1", 64'(bus.op1), 64'd0);
    check("t2_op2", 64'(bus.op2), 64'd0);
    check("t2_stall_cnt", 64'(stall_cnt), 64'd0);

    // Same-cycle write forwarding
    pend = '0;
    set_reg(7, 33'h0_0000_1234);
    R_in = 32'h1 << 7; G = 33'h0_0000_ABCD;
    bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    step();
    R_in = '0; G = '0;
    check("t3_op1_fwd", 64'(bus.op1), 64'h0_0000_ABCD);
    check("t3_op2", 64'(bus.op2), 64'h0_0000_0011);

    // Hazard on rs2=9 for four cycles
    set_reg(9, 33'h0_0000_0099);
    pend = 32'h1 << 9;
    bus.rs1 = 5'd0; bus.rs2 = 5'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_in_ready_stall%0d", i), 64'(bus.in_ready), 64'd0);
      step();
    end
    check("t4_stall_cnt", 64'(stall_cnt), 64'd4);
    check("t4_drained", 64'(bus.out_valid), 64'd0);
    pend = '0;
    #1;
    check("t4_in_ready_clear", 64'(bus.in_ready), 64'd1);
    step();
    check("t4_out_valid", 64'(bus.out_valid), 64'd1);
    check("t4_op2", 64'(bus.op2), 64'h0_0000_0099);
    check("t4_stall_hold", 64'(stall_cnt), 64'd4);

    // Back-to-back with 2 cycles of backpressure after the first
    set_reg(1, 33'h0_0000_0101); set_reg(2, 33'h0_0000_0202);
    set_reg(4, 33'h0_0000_0404); set_reg(6, 33'h1_0000_0606);
    set_reg(8, 33'h0_0000_0808); set_reg(10, 33'h0_0000_0A0A);
    bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    step();
    check("t5_a_op1", 64'(bus.op1), 64'h101);
    check("t5_a_op2", 64'(bus.op2), 64'h202);
    bus.out_ready = 1'b0;
    bus.rs1 = 5'd4; bus.rs2 = 5'd6;
    #1;
    check("t5_full_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("t5_hold1_op1", 64'(bus.op1), 64'h101);
    check("t5_hold1_valid", 64'(bus.out_valid), 64'd1);
    check("t5_hold1_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("t5_hold2_op2", 64'(bus.op2), 64'h202);
    check("t5_hold2_stall_cnt", 64'(stall_cnt), 64'd4);
    bus.out_ready = 1'b1;
    #1;
    check("t5_resume_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("t5_b_op1", 64'(bus.op1), 64'h404);
    check("t5_b_op2", 64'(bus.op2), 64'h1_0000_0606);
    bus.rs1 = 5'd8; bus.rs2 = 5'd10;
    step();
    bus.in_valid = 1'b0;
    check("t5_c_valid", 64'(bus.out_valid), 64'd1);
    check("t5_c_op1", 64'(bus.op1), 64'h808);
    check("t5_c_op2", 64'(bus.op2), 64'hA0A);
    step();
    check("t5_drain_valid", 64'(bus.out_valid), 64'd0);
    check("t5_drain_op1_kept", 64'(bus.op1), 64'h808);
    check("t5_stall_final", 64'(stall_cnt), 64'd4);

    // rs1==rs2, then asynchronous reset while holding
    bus.rs1 = 5'd5; bus.rs2 = 5'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_op1_same", 64'(bus.op1), 64'h1_0000_0022);
    check("t6_op2_same", 64'(bus.op2), 64'h1_0000_0022);
    check("t6_valid", 64'(bus.out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_arst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_arst_op1", 64'(bus.op1), 64'd0);
    check("t6_arst_op2", 64'(bus.op2), 64'd0);
    check("t6_arst_stall_cnt", 64'(stall_cnt), 64'd0);
    step();
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regread_port.md
Name: regread_port

Overview:
- Read side of the 32-entry general register array: accepts a two-operand read request (rs1, rs2) and returns both operands (XLEN+1 bits each) through a registered valid/ready stage.
- Forwards a write committing in the same cycle (G with a one-hot R_in), so a read never sees a stale value.
- Stalls requests whose source register has a pending write in the scoreboard.
- Sits between the decode stage and the execute/ALU stage.

Parameters:
XLEN, 32, data width; register words are XLEN+1 bits (bit XLEN is the tag bit carried by the array)

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
regs_flat  input  32*(XLEN+1)  concatenated register outputs r0..r31; rk at bits [k*(XLEN+1) +: XLEN+1]
G  input  XLEN+1  write data being presented to the array this cycle
R_in  input  XLEN  per-register write enables, same encoding as the array; bit 0 ignored
pend  input  XLEN  scoreboard: bit k=1 means a write to rk is outstanding; bit 0 ignored
in_valid  input  1  read request valid
in_ready  output  1  request accepted when in_valid && in_ready
rs1  input  5  source register 1 index
rs2  input  5  source register 2 index
out_valid  output  1  operands valid
out_ready  input  1  consumer accepts operands
op1  output  XLEN+1  operand for rs1
op2  output  XLEN+1  operand for rs2
stall_cnt  output  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (resetn=0, asynchronous): out_valid=0, op1=op2=0, stall_cnt=0. Reset asserted mid-transfer drops the held operands. No request is accepted during reset.
- Operand select per source s (combinational):
  - s==0 -> 0, regardless of pend or R_in.
  - else R_in[s]==1 -> G (forward).
  - else -> r_s from regs_flat.
- Hazard:
  - hazard = in_valid && ((rs1!=0 && pend[rs1] && !R_in[rs1]) || (rs2!=0 && pend[rs2] && !R_in[rs2])).
  - A write committing this cycle clears the hazard for that source.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - The output stage holds op1/op2/out_valid stable while out_valid && !out_ready.
- Output stage, per cycle:
  - Accept (in_valid && in_ready): op1/op2 <= selected values, out_valid <= 1. Latency is 1 cycle.
  - Else if out_ready: out_valid <= 0, op1/op2 keep their last value.
  - Simultaneous drain and accept gives back-to-back throughput of 1 request/cycle.
- Snapshot semantics: held operands are not refreshed by later writes. Operands reflect register state as of the accepting edge, including a write committing at that edge.
- Effective FSM, derived from out_valid and hazard:
  - EMPTY (out_valid=0): -> FULL on accept.
  - FULL (out_valid=1): -> EMPTY on out_ready without accept; stays FULL on accept+out_ready or on !out_ready.
  - STALL is an input condition, not stored state: in_valid && hazard keeps in_ready=0 in either state.
- stall_cnt increments by 1 each cycle in_valid && hazard and saturates at 16'hFFFF. It does not count backpressure-only cycles (out_valid && !out_ready).
- rs1==rs2 is legal and gives identical operands.

Decomposition:
- Package regfile_pkg:
  - XLEN default; REG_COUNT=32; ADDR_W=5; WORD_W=XLEN+1.
  - Helper to extract word k from regs_flat.
- Sub-module regsel: 32:1 word mux with x0 zeroing and R_in/G forwarding, plus the per-source hazard bit. Instantiated twice (rs1, rs2).
- Top level holds the output register, handshake logic and stall counter.

Test Plan:
- Reset, then rs1=3, rs2=5 with r3=0x0_0000_0011, r5=0x1_0000_0022, pend=0, out_ready=1 -> next cycle out_valid=1, op1=0x011, op2=0x1_0000_0022.
- rs1=0, rs2=0 with pend=all-ones and R_in[0]=1, G=0x1FFFFFFFF -> accepted with no stall; op1=op2=0.
- rs1=7 with R_in[7]=1, G=0xABCD and r7=0x1234 in the same cycle -> op1=0xABCD (forwarded).
- pend[9]=1, rs2=9 held for 4 cycles, then pend[9]=0 -> in_ready=0 for those 4 cycles, stall_cnt=4, accept on cycle 5.
- Three back-to-back requests with out_ready=0 for 2 cycles after the first -> first operands stay stable, in_ready=0 while full, stall_cnt unchanged, then one output per cycle with none lost.
- Drive resetn=0 asynchronously while out_valid=1 -> out_valid, op1, op2 and stall_cnt go to 0 without a clock edge.
